// File: rtl/snap_phase_pkg.sv
// Shared constants for the phase snapshot controller: FSM encoding,
// control-word field positions and status-word bit positions.
package snap_phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int CHAN_W = 9;

    localparam int CTRL_ARM_BIT       = 0;
    localparam int CTRL_TRIG_MODE_BIT = 1;
    localparam int CTRL_CHAN_ALL_BIT  = 2;
    localparam int CTRL_CHAN_SEL_LSB  = 4;

    localparam int STAT_DONE_BIT = 31;
    localparam int STAT_BUSY_BIT = 30;

    function automatic logic is_busy(input state_t st);
        return (st == ST_ARMED) || (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/snap_phase_qual.sv
// Sample qualifier: accepts a valid sample while capturing when either all
// channels are selected or the sample's channel equals the selected one.
module snap_phase_qual
    import snap_phase_pkg::*;
(
    input  logic              enable,
    input  logic              in_valid,
    input  logic              chan_all,
    input  logic [CHAN_W-1:0] chan_sel,
    input  logic [CHAN_W-1:0] chan_in,
    output logic              sample_ok
);

    logic chan_match;

    assign chan_match = chan_all || (chan_in == chan_sel);
    assign sample_ok  = enable && in_valid && chan_match;

endmodule

// File: rtl/snap_phase_ctrl.sv
// Phase snapshot capture controller: arms on a rising edge of the arm bit,
// optionally waits for an external trigger, then writes qualified samples.
module snap_phase_ctrl
    import snap_phase_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_reg,
    input  logic              ext_trig,
    input  logic              in_valid,
    input  logic [8:0]        chan_in,
    input  logic [DATA_W-1:0] phase_in,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [31:0]       status_addr
);

    // Count needs ADDR_W+1 bits so a full buffer reads back as 2**ADDR_W;
    // it must also fit below the busy bit of the status word (ADDR_W <= 29).
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

    logic              arm_lvl;
    logic              trig_ext;
    logic              chan_all;
    logic [CHAN_W-1:0] chan_sel;
    logic              unused_ctrl;

    assign arm_lvl     = ctrl_reg[CTRL_ARM_BIT];
    assign trig_ext    = ctrl_reg[CTRL_TRIG_MODE_BIT];
    assign chan_all    = ctrl_reg[CTRL_CHAN_ALL_BIT];
    assign chan_sel    = ctrl_reg[CTRL_CHAN_SEL_LSB +: CHAN_W];
    assign unused_ctrl = ^{ctrl_reg[31:13], ctrl_reg[3]};

    state_t            state_q, state_d;
    logic              arm_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [31:0]       status_q, status_d;

    logic arm_edge;
    logic sample_ok;
    logic last_slot;

    assign arm_edge  = arm_lvl && !arm_q;
    assign last_slot = (count_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

    snap_phase_qual u_qual (
        .enable    (state_q == ST_CAPTURE),
        .in_valid  (in_valid),
        .chan_all  (chan_all),
        .chan_sel  (chan_sel),
        .chan_in   (chan_in),
        .sample_ok (sample_ok)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_edge) begin
                    count_d = '0;
                    state_d = trig_ext ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                // Dropping arm while waiting cancels; the trigger cycle's
                // own sample is never captured since qualify needs CAPTURE.
                if (!arm_lvl) begin
                    state_d = ST_IDLE;
                end else if (ext_trig) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sample_ok) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    din_d   = phase_in;
                    count_d = count_q + COUNT_ONE;
                    if (last_slot) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        status_d                = '0;
        status_d[STAT_DONE_BIT] = (state_q == ST_DONE);
        status_d[STAT_BUSY_BIT] = is_busy(state_q);
        status_d[ADDR_W:0]      = count_q;
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q  <= ST_IDLE;
            arm_q    <= 1'b0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_lvl;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            status_q <= status_d;
        end
    end

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_din    = din_q;
    assign status_addr = status_q;

endmodule

// File: doc/snap_phase_ctrl.md
SNAP_PHASE_CTRL -- requirements
Module: snap_phase_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning snapshot BRAM address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, meaning phase sample width.
REQ-003 SHALL have port user_clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port user_rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port ctrl_reg  input  32  meaning software control word: bit0 arm, bit1 trig_mode (0 immediate, 1 external), bit2 chan_all, bits[12:4] chan_sel.
REQ-006 SHALL have port ext_trig  input  1  meaning external capture trigger, level-sampled.
REQ-007 SHALL have port in_valid  input  1  meaning phase_in/chan_in qualifier.
REQ-008 SHALL have port chan_in  input  9  meaning channel index of the current sample (512 channels).
REQ-009 SHALL have port phase_in  input  DATA_W  meaning phase sample.
REQ-010 SHALL have port bram_we  output  1  meaning snapshot BRAM write enable.
REQ-011 SHALL have port bram_addr  output  ADDR_W  meaning snapshot BRAM write address.
REQ-012 SHALL have port bram_din  output  DATA_W  meaning snapshot BRAM write data.
REQ-013 SHALL have port status_addr  output  32  meaning readback word for the snapPhase_addr register: bit31 done, bit30 busy, bits[ADDR_W:0] samples written.

Function
REQ-014 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-015 SHALL detect arm as a registered rising edge of ctrl_reg[0]; a level held high SHALL NOT re-trigger.
REQ-016 IDLE or DONE + arm edge SHALL clear the sample count to 0 and go to ARMED (trig_mode=1) or CAPTURE (trig_mode=0) next cycle.
REQ-017 ARMED SHALL go to CAPTURE on the first cycle ext_trig=1; ARMED with ctrl_reg[0]=0 SHALL return to IDLE.
REQ-018 CAPTURE SHALL qualify a sample when in_valid=1 and (chan_all=1 or chan_in=chan_sel); ARMED-cycle samples SHALL NOT be captured, even in the trigger cycle.
REQ-019 Each qualified sample SHALL produce bram_we=1 one cycle later, bram_din=the registered phase_in, bram_addr=current count[ADDR_W-1:0].
REQ-020 count SHALL increment by 1 per write; the write at address 2**ADDR_W-1 SHALL move the state to DONE in the same cycle, count=2**ADDR_W, with no address wrap.
REQ-021 ctrl_reg[0] falling during CAPTURE SHALL NOT abort capture.
REQ-022 An arm edge during ARMED or CAPTURE SHALL be ignored.
REQ-023 DONE SHALL hold bram_we=0 and count stable until the next arm edge.
REQ-024 status_addr SHALL be registered: bit31=(state==DONE), bit30=(state ARMED or CAPTURE), bits[ADDR_W:0]=count, other bits 0; one cycle latency from state/count.
REQ-025 chan_sel and chan_all SHALL be sampled every cycle; changes mid-capture take effect on the next sample.

Reset
REQ-026 user_rst=1 SHALL asynchronously force IDLE, count=0, arm-edge register=0, bram_we=0, bram_addr=0, bram_din=0, status_addr=0.
REQ-027 Reset asserted mid-CAPTURE SHALL abandon capture; a fresh arm edge is required after release.

Structure
REQ-028 State encoding, ctrl_reg bit positions and status bit positions SHALL be constants in shared package snap_phase_pkg.
REQ-029 The channel-match/qualify logic SHALL be a separate sub-module snap_phase_qual; FSM and counter stay in the top.

Verification
REQ-030 Immediate mode, chan_all=1, ADDR_W=4, in_valid continuous -> 16 writes at addr 0..15, data matching phase_in, then status_addr=0x80000010.
REQ-031 External mode, chan_sel=5 -> bram_we=0 before ext_trig; after trigger only chan_in=5 samples written; busy bit set until the 16th write.
REQ-032 Arm held high after DONE -> no new capture; toggle arm 0->1 -> count clears to 0, status bit31 clears.
REQ-033 Arm dropped in ARMED -> IDLE, status_addr=0; arm dropped in CAPTURE -> capture completes.
REQ-034 user_rst pulsed after 7 writes -> all outputs 0 immediately; re-arm -> writes restart at addr 0.
REQ-035 in_valid gapped (1 of 3 cycles) -> addresses contiguous, no skipped or duplicated entries.
